// File: rtl/bcd_readout.sv
// Purpose : snapshot four cascaded BCD decade-counter digits on capture and
//           stream them out thousands-first, units-last, one digit per transfer.
// Latency : tx_valid/busy rise on the capture edge; one digit per accepted beat;
//           busy drops on the edge of the 4th transfer.
// Backpressure: tx_data/tx_valid/tx_last hold while tx_ready=0; capture is
//           ignored while a readout is in progress.
//
// Ports:
//   clock, reset (async, active-low)
//   digits_in[15:0]  four BCD digits, [3:0] units ... [15:12] thousands
//   tc_in            terminal-count pulse from the thousands counter
//   capture          snapshot request (honoured only in IDLE)
//   tx_ready         downstream accepts tx_data this cycle
//   tx_data/tx_valid/tx_last  digit stream, tx_last marks the units digit
//   busy             readout in progress
//   overflow         tc_in was seen in the window closed by the last capture
//   bcd_error        one-cycle pulse when a captured digit was >9
//
// Optional feature: define BCD_READOUT_CHECK_EN to replace invalid digits by
// 4'hF at capture and raise bcd_error; otherwise digits pass unmodified.

module bcd_readout (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic        tc_in,
  input  logic        capture,
  input  logic        tx_ready,
  output logic [3:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        busy,
  output logic        overflow,
  output logic        bcd_error
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] snapshot;
  logic [1:0]  idx;
  logic        sticky;
  logic        accept;
  logic        xfer;
  logic [15:0] snap_dat;

  // Value stored into the snapshot on an accepted capture.
`ifdef BCD_READOUT_CHECK_EN
  logic snap_bad;

  always_comb begin
    snap_dat = digits_in;
    snap_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (digits_in[4*i +: 4] > 4'd9) begin
        snap_dat[4*i +: 4] = 4'hF;
        snap_bad           = 1'b1;
      end
    end
  end
`else
  assign snap_dat = digits_in;
`endif

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    busy      = 1'b0;
    tx_data   = 4'd0;
    case (state)
      IDLE: begin
        if (capture) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        tx_data  = snapshot[{idx, 2'b00} +: 4];
        tx_last  = (idx == 2'd0);
        if (tx_ready) begin
          xfer = 1'b1;
          if (idx == 2'd0) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      snapshot <= 16'd0;
      idx      <= 2'd3;
      sticky   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        snapshot <= snap_dat;
        idx      <= 2'd3;
        // A tc_in coinciding with the capture both reports now and opens
        // the next window already flagged.
        overflow <= sticky | tc_in;
        sticky   <= tc_in;
      end else begin
        if (tc_in) begin
          sticky <= 1'b1;
        end
        // The final transfer re-arms the index rather than wrapping it.
        if (xfer) begin
          idx <= (idx == 2'd0) ? 2'd3 : idx - 2'd1;
        end
      end
    end
  end

`ifdef BCD_READOUT_CHECK_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcd_error <= 1'b0;
    end else begin
      bcd_error <= accept & snap_bad;
    end
  end
`else
  assign bcd_error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_readout.sv
module tb_bcd_readout;

`ifdef BCD_READOUT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [15:0] digits_in;
  logic        tc_in;
  logic        capture;
  logic        tx_ready;
  logic [3:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        busy;
  logic        overflow;
  logic        bcd_error;

  bcd_readout dut (
    .clock     (clock),
    .reset     (reset),
    .digits_in (digits_in),
    .tc_in     (tc_in),
    .capture   (capture),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .busy      (busy),
    .overflow  (overflow),
    .bcd_error (bcd_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks;
  int errors;

  // Reference model: a readout is a queue of pending digits.
  logic       m_busy;
  logic [3:0] m_q[$];
  logic       m_sticky;
  logic       m_ovf;
  logic       m_err;

  logic [8:0] dut_vec;
  assign dut_vec = {tx_valid, tx_last, busy, tx_data, overflow, bcd_error};

  function automatic void model_reset();
    m_busy   = 1'b0;
    m_q.delete();
    m_sticky = 1'b0;
    m_ovf    = 1'b0;
    m_err    = 1'b0;
  endfunction

  function automatic logic [3:0] map_digit(input logic [3:0] d);
    if (CHECK_EN && d > 4'd9) return 4'hF;
    return d;
  endfunction

  function automatic void model_edge(input logic cap, input logic [15:0] dig,
                                     input logic tc, input logic rdy);
    logic bad;
    logic [3:0] d;
    bad = 1'b0;
    if (m_busy) begin
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 1'b0;
      end
      m_err = 1'b0;
      if (tc) m_sticky = 1'b1;
    end else if (cap) begin
      m_q.delete();
      for (int i = 3; i >= 0; i--) begin
        d = dig[4*i +: 4];
        if (d > 4'd9) bad = 1'b1;
        m_q.push_back(map_digit(d));
      end
      m_busy   = 1'b1;
      m_ovf    = m_sticky | tc;
      m_sticky = tc;
      m_err    = bad & CHECK_EN;
    end else begin
      m_err = 1'b0;
      if (tc) m_sticky = 1'b1;
    end
  endfunction

  function automatic logic [8:0] exp_vec();
    logic [3:0] d;
    logic       last;
    d    = 4'd0;
    last = 1'b0;
    if (m_busy) begin
      d    = m_q[0];
      last = (m_q.size() == 1);
    end
    return {m_busy, last, m_busy, d, m_ovf, m_err};
  endfunction

  // Called in the low phase: drive inputs, cross one rising edge, update the
  // model, return in the next low phase.
  task automatic tick(input logic cap, input logic [15:0] dig,
                      input logic tc, input logic rdy);
    capture   = cap;
    digits_in = dig;
    tc_in     = tc;
    tx_ready  = rdy;
    @(posedge clock);
    model_edge(cap, dig, tc, rdy);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", dut_vec, 9'b0);
    end
    capture = 1'b1; digits_in = 16'h9999; tc_in = 1'b1; tx_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", dut_vec, 9'b0);
    end
    reset = 1'b1; capture = 1'b0; tc_in = 1'b0; tx_ready = 1'b0; digits_in = 16'h0;
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_basic();
    logic [3:0] sent[$];
    logic [3:0] want [4];
    int         last_cnt;
    logic [3:0] last_dig;
    want = '{4'd1, 4'd9, 4'd8, 4'd7};
    last_cnt = 0;
    last_dig = 4'd0;
    tick(1'b1, 16'h1987, 1'b0, 1'b1);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL basic_capture: got %b expected %b", dut_vec, exp_vec());
    end
    for (int c = 0; c < 6; c++) begin
      if (tx_valid) sent.push_back(tx_data);
      if (tx_last) begin
        last_cnt++;
        last_dig = tx_data;
      end
      tick(1'b0, 16'h1987, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL basic_cyc%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (sent.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 4", sent.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sent.size() || sent[i] !== want[i]) begin
        errors++;
        $display("FAIL basic_digit%0d: got %h expected %h", i,
                 (i < sent.size()) ? sent[i] : 4'hx, want[i]);
      end
    end
    checks++;
    if (last_cnt != 1 || last_dig !== 4'd7) begin
      errors++;
      $display("FAIL basic_last: got %0d cycles on %h expected 1 on 7", last_cnt, last_dig);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_end: got %b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic       pat [7];
    logic [3:0] sent[$];
    logic [3:0] want [4];
    logic [3:0] prev_d;
    logic       prev_hold;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    want = '{4'd0, 4'd4, 4'd5, 4'd9};
    prev_hold = 1'b0;
    prev_d    = 4'd0;
    tick(1'b1, 16'h0459, 1'b0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      logic r;
      r = (c < 7) ? pat[c] : 1'b1;
      if (prev_hold) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_d) begin
          errors++;
          $display("FAIL bp_hold%0d: got v=%b d=%h expected v=1 d=%h", c, tx_valid, tx_data, prev_d);
        end
      end
      if (tx_valid && r) sent.push_back(tx_data);
      prev_hold = tx_valid && !r;
      prev_d    = tx_data;
      tick(1'b0, 16'($urandom), 1'b0, r);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL bp_cyc%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (sent.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d expected 4", sent.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sent.size() || sent[i] !== want[i]) begin
        errors++;
        $display("FAIL bp_digit%0d: got %h expected %h", i,
                 (i < sent.size()) ? sent[i] : 4'hx, want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] dig [4];
    logic        tcv [4];
    logic        want [4];
    dig  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tcv  = '{1'b0, 1'b0, 1'b1, 1'b0};
    want = '{1'b1, 1'b0, 1'b1, 1'b1};
    tick(1'b0, 16'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, dig[k], tcv[k], 1'b1);
      checks++;
      if (overflow !== want[k] || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_capture%0d: got ovf=%b vec=%b expected ovf=%b vec=%b",
                 k, overflow, dut_vec, want[k], exp_vec());
      end
      for (int c = 0; c < 4; c++) begin
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL ovf_drain%0d_%0d: got %b expected %b", k, c, dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_capture_ignored();
    logic [3:0] sent[$];
    logic [3:0] want [4];
    want = '{4'd3, 4'd1, 4'd4, 4'd1};
    tick(1'b1, 16'h3141, 1'b0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      logic r;
      r = (c != 1);
      if (tx_valid && r) sent.push_back(tx_data);
      tick(c < 5, 16'h2222, 1'b0, r);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ign_cyc%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (sent.size() != 4 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ign_count: got %0d transfers valid=%b expected 4 valid=0", sent.size(), tx_valid);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sent.size() || sent[i] !== want[i]) begin
        errors++;
        $display("FAIL ign_digit%0d: got %h expected %h", i,
                 (i < sent.size()) ? sent[i] : 4'hx, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 16'h5678, 1'b1, 1'b1);
    tick(1'b0, 16'h5678, 1'b0, 1'b1);
    tick(1'b0, 16'h5678, 1'b0, 1'b1);
    checks++;
    if (tx_data !== 4'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got d=%h busy=%b expected d=7 busy=1", tx_data, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 9'b0) begin
      errors++;
      $display("FAIL mid_async: got %b expected %b", dut_vec, 9'b0);
    end
    capture = 1'b0; tx_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 16'h5678, 1'b0, 1'b1);
      checks++;
      if (tx_valid !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL mid_after%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_bcd();
    logic [3:0] sent[$];
    logic [3:0] want [4];
    int         err_cycles;
    want = '{4'd1, 4'd2, (CHECK_EN ? 4'hF : 4'hA), 4'd4};
    err_cycles = 0;
    tick(1'b1, 16'h12A4, 1'b0, 1'b1);
    checks++;
    if (bcd_error !== CHECK_EN || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL bcd_capture: got err=%b vec=%b expected err=%b vec=%b",
               bcd_error, dut_vec, CHECK_EN, exp_vec());
    end
    for (int c = 0; c < 5; c++) begin
      if (bcd_error) err_cycles++;
      if (tx_valid) sent.push_back(tx_data);
      tick(1'b0, 16'h0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL bcd_cyc%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (err_cycles != int'(CHECK_EN)) begin
      errors++;
      $display("FAIL bcd_pulse: got %0d cycles expected %0d", err_cycles, int'(CHECK_EN));
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= sent.size() || sent[i] !== want[i]) begin
        errors++;
        $display("FAIL bcd_digit%0d: got %h expected %h", i,
                 (i < sent.size()) ? sent[i] : 4'hx, want[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick(($urandom % 4) == 0, 16'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cyc%0d: got %b expected %b", c, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    capture   = 1'b0;
    digits_in = 16'h0;
    tc_in     = 1'b0;
    tx_ready  = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_capture_ignored();
    test_reset_mid();
    test_bcd();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_readout.md
BCD_READOUT -- requirements
Module: bcd_readout

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port digits_in, input, 16 bits: four BCD digits from cascaded decade counters; [3:0] is the units digit and [15:12] the thousands digit.
REQ-004 SHALL have port tc_in, input, 1 bit: terminal-count pulse from the thousands-digit counter.
REQ-005 SHALL have port capture, input, 1 bit: request to snapshot digits_in and start a readout.
REQ-006 SHALL have port tx_ready, input, 1 bit: downstream accepts tx_data this cycle.
REQ-007 SHALL have port tx_data, output, 4 bits: current digit being sent.
REQ-008 SHALL have port tx_valid, output, 1 bit: tx_data holds a valid digit.
REQ-009 SHALL have port tx_last, output, 1 bit: the current digit is the final (units) digit.
REQ-010 SHALL have port busy, output, 1 bit: a readout is in progress.
REQ-011 SHALL have port overflow, output, 1 bit: tc_in was seen in the window that ended at the last capture.
REQ-012 SHALL have port bcd_error, output, 1 bit: an invalid BCD digit was captured.

Function
REQ-013 SHALL implement a two-state FSM with states IDLE and SEND.
REQ-014 In IDLE with capture=1 at edge N, SHALL:
- register digits_in into a 16-bit snapshot;
- set digit index to 3;
- enter SEND;
- drive tx_valid=1 and busy=1 from edge N (one-cycle latency).
REQ-015 In SEND, tx_data SHALL equal snapshot digit[index]; digits are sent thousands first, units last.
REQ-016 A transfer SHALL occur only on an edge where tx_valid=1 and tx_ready=1; index SHALL decrement by 1 per transfer.
REQ-017 While tx_ready=0, tx_data, tx_valid and tx_last SHALL hold stable.
REQ-018 tx_last SHALL be 1 only while index=0 in SEND.
REQ-019 A transfer at index=0 SHALL return the FSM to IDLE and clear tx_valid, tx_last and busy on that same edge.
REQ-020 capture in SEND SHALL be ignored, with no effect on the snapshot or the index.
REQ-021 capture on the same edge that SEND returns to IDLE SHALL be ignored; a new readout starts only from IDLE.
REQ-022 An internal sticky flag SHALL set on any edge with tc_in=1.
REQ-023 On a capture accepted in IDLE, overflow SHALL load the sticky flag value and the sticky flag SHALL clear.
REQ-024 If tc_in=1 on the capture edge itself, the sticky flag SHALL remain set, and overflow SHALL also load 1.
REQ-025 overflow SHALL hold its value until the next accepted capture.
REQ-026 Exactly 4 transfers SHALL occur per readout; the index SHALL never wrap.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for a clock edge:
- force IDLE;
- set index=3;
- clear the snapshot and the sticky flag;
- drive tx_data=0, tx_valid=0, tx_last=0, busy=0, overflow=0, bcd_error=0.
REQ-028 Reset asserted in mid-readout SHALL abandon the readout; after reset release, no digit transfers until a new capture.
REQ-029 Reset release SHALL take effect synchronously to clock, with the first capture honoured on the first rising edge after release.

Configuration
REQ-030 Macro BCD_READOUT_CHECK_EN defined: on an accepted capture, any digit >9 SHALL be stored as 4'hF.
REQ-031 Macro BCD_READOUT_CHECK_EN defined: bcd_error SHALL pulse high for exactly one cycle, starting on the capture edge, if any digit was >9.
REQ-032 Macro BCD_READOUT_CHECK_EN undefined: digits SHALL be stored and sent unmodified, and bcd_error SHALL be constant 0.

Verification
REQ-033 digits_in=16'h1987, capture 1 cycle, tx_ready=1 -> tx_data 1,9,8,7 on 4 consecutive cycles; tx_last only on 7; busy low after the 4th transfer.
REQ-034 digits_in=16'h0459, tx_ready toggling 1,0,0,1,1,0,1 -> digits 0,4,5,9 each held stable while tx_ready=0; exactly 4 transfers.
REQ-035 tc_in pulse, then capture -> overflow=1; second capture with no tc_in -> overflow=0; tc_in on the capture edge -> overflow=1 and next capture also overflow=1.
REQ-036 capture pulsed during SEND with digits_in changed to 16'h2222 -> original digits complete unchanged; no second readout starts.
REQ-037 reset=0 asserted after the 2nd transfer of 16'h5678 -> all outputs 0 at once; after release, tx_valid stays 0 until a new capture.
REQ-038 With BCD_READOUT_CHECK_EN, digits_in=16'h12A4 -> sent 1,2,F,4 and bcd_error high for one cycle; without the macro -> sent 1,2,A,4 and bcd_error stays 0.
